// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter sharing one slave between NM masters.
// The grant is held through fixed bursts, undefined-length INCR bursts and locked tenures.
//
// state     | meaning
// IDLE_PARK | nobody requesting, grant parked on the last owner
// OWNED     | owner holds the bus and may be replaced
// BURST     | fixed-length burst in progress, grant frozen
// LOCKED    | locked tenure, frozen until owner drops hlock and goes IDLE/NONSEQ
module ahb_arbiter #(
  parameter int NM = 2,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int MW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NM-1:0]        m_hbusreq,
  input  logic [NM-1:0]        m_hlock,
  input  logic [NM*AW-1:0]     m_haddr,
  input  logic [NM*2-1:0]      m_htrans,
  input  logic [NM-1:0]        m_hwrite,
  input  logic [NM*3-1:0]      m_hsize,
  input  logic [NM*3-1:0]      m_hburst,
  input  logic [NM*DW/8-1:0]   m_hwstrb,
  input  logic [NM*DW-1:0]     m_hwdata,
  output logic [NM-1:0]        m_hgrant,
  output logic [MW-1:0]        hmaster,
  output logic                 hmastlock,
  output logic [AW-1:0]        s_haddr,
  output logic [1:0]           s_htrans,
  output logic                 s_hwrite,
  output logic [2:0]           s_hsize,
  output logic [2:0]           s_hburst,
  output logic [DW/8-1:0]      s_hwstrb,
  output logic [DW-1:0]        s_hwdata,
  input  logic                 hready,
  input  logic                 hresp
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic [1:0] {IDLE_PARK, OWNED, BURST, LOCKED} state_t;

  state_t         state;
  logic [MW-1:0]  data_owner;
  logic [MW-1:0]  rr_ptr;
  logic [3:0]     beat_cnt;

  logic           own_hlock;
  logic [3:0]     cnt_nx;
  logic           incr_hold;
  logic           lock_hold;
  logic           can_arb;
  logic           any_req;
  logic           win_lock;
  logic [MW-1:0]  win;
  logic [MW-1:0]  rr_nx;

  function automatic logic [3:0] burst_len(input logic [2:0] hb);
    case (hb)
      3'b010, 3'b011: burst_len = 4'd3;
      3'b100, 3'b101: burst_len = 4'd7;
      3'b110, 3'b111: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  endfunction

  always_comb begin
    s_haddr   = '0;
    s_htrans  = TR_IDLE;
    s_hwrite  = 1'b0;
    s_hsize   = '0;
    s_hburst  = '0;
    own_hlock = 1'b0;
    s_hwstrb  = '0;
    s_hwdata  = '0;
    for (int i = 0; i < NM; i++) begin
      m_hgrant[i] = (hmaster == MW'(i));
      if (hmaster == MW'(i)) begin
        s_haddr   = m_haddr[i*AW +: AW];
        s_htrans  = m_htrans[i*2 +: 2];
        s_hwrite  = m_hwrite[i];
        s_hsize   = m_hsize[i*3 +: 3];
        s_hburst  = m_hburst[i*3 +: 3];
        own_hlock = m_hlock[i];
      end
      if (data_owner == MW'(i)) begin
        s_hwstrb = m_hwstrb[i*(DW/8) +: DW/8];
        s_hwdata = m_hwdata[i*DW +: DW];
      end
    end
  end

  // Round robin: lowest requester at or above rr_ptr, otherwise lowest overall.
  always_comb begin
    any_req  = 1'b0;
    win      = hmaster;
    win_lock = 1'b0;
    for (int i = NM-1; i >= 0; i--) begin
      if (m_hbusreq[i] && (MW'(i) >= rr_ptr)) begin
        any_req  = 1'b1;
        win      = MW'(i);
        win_lock = m_hlock[i];
      end
    end
    if (!any_req) begin
      for (int i = NM-1; i >= 0; i--) begin
        if (m_hbusreq[i]) begin
          any_req  = 1'b1;
          win      = MW'(i);
          win_lock = m_hlock[i];
        end
      end
    end
    rr_nx = (win == MW'(NM-1)) ? '0 : win + MW'(1);
  end

  // An INCR NONSEQ also holds the grant so an undefined-length burst is never split after its first beat.
  always_comb begin
    cnt_nx = beat_cnt;
    if (s_htrans == TR_NONSEQ)
      cnt_nx = burst_len(s_hburst);
    else if (s_htrans == TR_SEQ && beat_cnt != 4'd0)
      cnt_nx = beat_cnt - 4'd1;
    incr_hold = (s_hburst == HB_INCR) && (s_htrans != TR_IDLE);
    lock_hold = (state == LOCKED) &&
                (own_hlock || s_htrans == TR_SEQ || s_htrans == TR_BUSY);
    can_arb   = (cnt_nx == 4'd0) && !lock_hold && !incr_hold;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE_PARK;
      hmaster    <= '0;
      data_owner <= '0;
      rr_ptr     <= '0;
      beat_cnt   <= '0;
      hmastlock  <= 1'b0;
    end else if (!hready) begin
      // First ERROR cycle abandons the burst; otherwise a wait state holds everything.
      if (hresp) begin
        beat_cnt <= '0;
        if (state == BURST) state <= OWNED;
      end
    end else begin
      data_owner <= hmaster;
      beat_cnt   <= cnt_nx;
      if (can_arb) begin
        if (any_req) begin
          hmaster   <= win;
          rr_ptr    <= rr_nx;
          state     <= win_lock ? LOCKED : OWNED;
          hmastlock <= win_lock;
        end else begin
          state     <= IDLE_PARK;
          hmastlock <= 1'b0;
        end
      end else begin
        if (lock_hold)
          state <= LOCKED;
        else if (cnt_nx != 4'd0)
          state <= BURST;
        else
          state <= OWNED;
        hmastlock <= lock_hold;
      end
    end
  end

endmodule
